auto_bcd_counter_mux: RTL

Parametrised successor to the single-digit auto-counter. Multi-digit BCD counter advanced by an internal prescaled tick, with switch-selectable rate, count direction, pause, synchronous clear and optional leading-zero blanking. Drives DIGITS active-low seven-segment displays directly. Sits at board top level between switches and the HEX outputs.

---
 rtl/seven_seg_pkg.sv | 52 +++++
 rtl/tick_gen.sv | 54 +++++
 rtl/auto_bcd_counter_mux.sv | 127 ++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment patterns (active-low, segment a in the MSB), rate multipliers
// and small elaboration-time helpers for the BCD counter display slice.
`timescale 1ns/1ps
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int unsigned SPD_MULT_00 = 1;
  localparam int unsigned SPD_MULT_01 = 2;
  localparam int unsigned SPD_MULT_10 = 4;
  localparam int unsigned SPD_MULT_11 = 12;

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    case (nibble)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Only ever evaluated on parameters, so it folds to a constant.
  function automatic logic [31:0] to_bcd(input int unsigned value);
    logic [31:0] result;
    int unsigned rest;
    result = '0;
    rest   = value;
    for (int i = 0; i < 8; i++) begin
      result[4*i +: 4] = 4'(rest % 10);
      rest = rest / 10;
    end
    return result;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle strobe every BASE_PERIOD*mult cycles; holds while
// paused and restarts from zero on clear or on a change of the rate select.
`timescale 1ns/1ps
module tick_gen
  import seven_seg_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] spd,
  output logic       tick
);

  localparam logic [31:0] LAST_00 = 32'(BASE_PERIOD * SPD_MULT_00 - 1);
  localparam logic [31:0] LAST_01 = 32'(BASE_PERIOD * SPD_MULT_01 - 1);
  localparam logic [31:0] LAST_10 = 32'(BASE_PERIOD * SPD_MULT_10 - 1);
  localparam logic [31:0] LAST_11 = 32'(BASE_PERIOD * SPD_MULT_11 - 1);

  logic [31:0] prescale;
  logic [31:0] period_last;
  logic [1:0]  spd_q;
  logic        spd_changed;

  always_comb begin
    period_last = LAST_00;
    case (spd)
      2'b01:   period_last = LAST_01;
      2'b10:   period_last = LAST_10;
      2'b11:   period_last = LAST_11;
      default: period_last = LAST_00;
    endcase
  end

  // A rate change suppresses the strobe so a shorter period cannot fire early.
  assign spd_changed = (spd != spd_q);
  assign tick        = en && !clr && !spd_changed && (prescale == period_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
      spd_q    <= '0;
    end else begin
      spd_q <= spd;
      if (clr || spd_changed || tick)
        prescale <= '0;
      else if (en)
        prescale <= prescale + 32'd1;
    end
  end

endmodule

// File: rtl/auto_bcd_counter_mux.sv
// Multi-digit BCD up/down counter stepped by tick_gen, driving active-low
// seven-segment displays with optional leading-zero blanking.
`timescale 1ns/1ps
module auto_bcd_counter_mux
  import seven_seg_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int MOD    = 100,
  parameter int CLK_HZ = 50000000
) (
  input  logic                CLOCK_50,
  input  logic                KEY0,
  input  logic                SW_CLR,
  input  logic                SW_EN,
  input  logic                SW_DIR,
  input  logic [1:0]          SW_SPD,
  input  logic                SW_BLANK,
  output logic [0:7*DIGITS-1] HEX,
  output logic                TICK,
  output logic                WRAP
);

  generate
    if (DIGITS < 1 || DIGITS > 8 || MOD < 2 || MOD > 10**DIGITS) begin : g_bad_params
      $error("auto_bcd_counter_mux: illegal DIGITS/MOD combination");
    end
  endgenerate

  localparam logic [31:0]         MAX_BCD_ALL = to_bcd(MOD - 1);
  localparam logic [4*DIGITS-1:0] MAX_BCD     = MAX_BCD_ALL[4*DIGITS-1:0];

  logic [4*DIGITS-1:0] count;
  logic [4*DIGITS-1:0] count_next;
  logic                wrap_next;
  logic                tick;
  logic                carry;
  logic [3:0]          nib;
  logic                upper_zero;
  logic [3:0]          dnib;

  tick_gen #(
    .BASE_PERIOD(CLK_HZ / 2)
  ) u_tick_gen (
    .clk  (CLOCK_50),
    .rst_n(KEY0),
    .clr  (SW_CLR),
    .en   (SW_EN),
    .spd  (SW_SPD),
    .tick (tick)
  );

  // Per-digit ripple: carry (up) or borrow (down) moves left while a digit rolls over.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    carry      = 1'b1;
    nib        = '0;
    if (!SW_DIR) begin
      if (count == MAX_BCD) begin
        count_next = '0;
        wrap_next  = 1'b1;
      end else begin
        for (int d = 0; d < DIGITS; d++) begin
          nib = count[4*d +: 4];
          if (carry) begin
            if (nib == 4'd9) begin
              count_next[4*d +: 4] = 4'd0;
            end else begin
              count_next[4*d +: 4] = nib + 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
    end else begin
      if (count == '0) begin
        count_next = MAX_BCD;
        wrap_next  = 1'b1;
      end else begin
        for (int d = 0; d < DIGITS; d++) begin
          nib = count[4*d +: 4];
          if (carry) begin
            if (nib == 4'd0) begin
              count_next[4*d +: 4] = 4'd9;
            end else begin
              count_next[4*d +: 4] = nib - 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      count <= '0;
      TICK  <= 1'b0;
      WRAP  <= 1'b0;
    end else if (SW_CLR) begin
      count <= '0;
      TICK  <= 1'b0;
      WRAP  <= 1'b0;
    end else begin
      TICK <= tick;
      WRAP <= tick && wrap_next;
      if (tick)
        count <= count_next;
    end
  end

  // Scan from the most significant digit so upper_zero covers all higher digits.
  always_comb begin
    HEX        = '1;
    upper_zero = 1'b1;
    dnib       = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      dnib = count[4*d +: 4];
      if (SW_BLANK && d > 0 && upper_zero && dnib == 4'd0)
        HEX[7*d +: 7] = SEG_BLANK;
      else
        HEX[7*d +: 7] = seg_decode(dnib);
      upper_zero = upper_zero && (dnib == 4'd0);
    end
  end

endmodule
